// File: rtl/reg_dump.sv
// reg_dump: walks register indices 0..LAST_REG through a synchronous read port and streams each
// word out over valid/ready. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word.
module reg_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LAST_REG = 31
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD = 3'd1, CAP = 3'd2, SEND = 3'd3, CSUM = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD = 3'd1, CAP = 3'd2, SEND = 3'd3
  } state_t;
`endif

  state_t            state_r;
  logic [ADDR_W-1:0] counter_r;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  function automatic logic [DATA_W-1:0] csum_next(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction
`endif

  // Dump sequencer; i_rdata arrives one cycle after o_raddr, hence the RD -> CAP split.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      counter_r  <= IDX_ZERO;
      o_raddr    <= IDX_ZERO;
      o_data     <= DATA_ZERO;
      o_index    <= IDX_ZERO;
      o_last     <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      checksum_r <= DATA_ZERO;
`endif
    end else begin
      o_done <= 1'b0;
      if (i_abort && (state_r != IDLE)) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
        o_busy  <= 1'b0;
        state_r <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (i_start) begin
              counter_r  <= IDX_ZERO;
              o_raddr    <= IDX_ZERO;
              o_busy     <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
              checksum_r <= DATA_ZERO;
`endif
              state_r    <= RD;
            end else begin
              state_r <= IDLE;
            end
          end
          RD: begin
            state_r <= CAP;
          end
          CAP: begin
            o_data     <= i_rdata;
            o_index    <= counter_r;
            o_valid    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            o_last     <= 1'b0;
            checksum_r <= csum_next(checksum_r, i_rdata);
`else
            o_last     <= (counter_r == LAST_IDX);
`endif
            state_r    <= SEND;
          end
          SEND: begin
            if (i_ready) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              if (counter_r < LAST_IDX) begin
                counter_r <= counter_r + IDX_ONE;
                o_raddr   <= counter_r + IDX_ONE;
                state_r   <= RD;
              end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                // checksum already folds in the word just accepted
                o_data  <= checksum_r;
                o_index <= IDX_ZERO;
                o_last  <= 1'b1;
                o_valid <= 1'b1;
                state_r <= CSUM;
`else
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
                state_r <= IDLE;
`endif
              end
            end else begin
              state_r <= SEND;
            end
          end
`ifdef REG_DUMP_CHECKSUM_EN
          CSUM: begin
            if (i_ready) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= CSUM;
            end
          end
`endif
          default: begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
